// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default data width, master FSM states and
// the byte-wide data type used across the stream blocks.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } axis_m_state_t;

    typedef logic [AXIS_DATA_W-1:0] axis_data_t;

endpackage : axis_pkg

// File: rtl/axis_sync_fifo.sv
// Single-clock register-array FIFO with first-word fall-through read.
// rd_data always shows the entry at the read pointer; a push while full and
// a pop while empty are both ignored.
module axis_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write on an accepted push.
    // NOTE: the array has no reset; occupancy gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : axis_sync_fifo

// File: rtl/axis_m_pkt_gen.sv
// AXI-Stream packet generator: bytes pushed by a local producer are queued
// in a FIFO and, on a start pulse, a packet of the programmed length is sent
// on m_axis_* with tlast on the final beat. An empty FIFO mid-packet simply
// drops tvalid (a bubble) until the next byte lands.
module axis_m_pkt_gen
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     m_axis_aclk,
    input  logic                     m_axis_aresetn,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     start,
    input  logic [LEN_W-1:0]         pkt_len,
    output logic                     busy,
    output logic                     pkt_done,
    output logic                     m_axis_tvalid,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    axis_m_state_t     state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              handshake;

    axis_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (m_axis_aclk),
        .aresetn (m_axis_aresetn),
        .wr_en   (din_valid),
        .wr_data (din),
        .rd_en   (handshake),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // All stream outputs derive from registers only (state, count, counters),
    // never from tready, so they hold steady through backpressure.
    assign din_ready     = !fifo_full;
    assign busy          = (state == SEND);
    assign m_axis_tvalid = busy && !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? head : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == len_q - LEN_W'(1));
    assign handshake     = m_axis_tvalid && m_axis_tready;

    // Packet FSM: latch length on start, count beats, return to IDLE on the tlast handshake.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state    <= IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
                        beat_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (m_axis_tlast) begin
                            state    <= IDLE;
                            pkt_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : axis_m_pkt_gen

// File: tb/tb_axis_m_pkt_gen.sv
// Bench for axis_m_pkt_gen. The reference model keeps the accepted push
// bytes and accepted packet lengths; the expected stream is every byte in
// push order, with tlast at each cumulative packet boundary.
module tb_axis_m_pkt_gen;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              start;
    logic [LEN_W-1:0]  pkt_len;
    logic              busy;
    logic              pkt_done;
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tready;
    logic [CW-1:0]     fifo_count;

    axis_m_pkt_gen #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .start          (start),
        .pkt_len        (pkt_len),
        .busy           (busy),
        .pkt_done       (pkt_done),
        .m_axis_tvalid  (tvalid),
        .m_axis_tdata   (tdata),
        .m_axis_tlast   (tlast),
        .m_axis_tready  (tready),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DATA_W-1:0] push_q [$];
    logic [DATA_W:0]   obs_q  [$];
    int                len_q  [$];
    int                done_cnt;
    int                stab_viol;
    bit                stalled;
    logic [DATA_W-1:0] st_data;
    logic              st_last;

    function automatic int total_beats();
        int s = 0;
        foreach (len_q[k]) s += len_q[k];
        return s;
    endfunction

    function automatic logic [DATA_W:0] exp_beat(int idx);
        int   s    = 0;
        logic last = 1'b0;
        foreach (len_q[k]) begin
            s += len_q[k];
            if (idx == s - 1) last = 1'b1;
        end
        return {last, (idx < push_q.size()) ? push_q[idx] : {DATA_W{1'bx}}};
    endfunction

    // One clock: record what the edge will accept, advance, then observe at edge+1.
    task automatic tick();
        if (din_valid && din_ready) push_q.push_back(din);
        if (start && !busy) len_q.push_back((pkt_len == '0) ? 1 : int'(pkt_len));
        if (tvalid && tready) obs_q.push_back({tlast, tdata});
        stalled = tvalid && !tready;
        st_data = tdata;
        st_last = tlast;
        @(posedge clk);
        #1;
        if (pkt_done) done_cnt++;
        if (stalled && (tvalid !== 1'b1 || tdata !== st_data || tlast !== st_last)) stab_viol++;
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        din       = '0;
        din_valid = 1'b0;
        start     = 1'b0;
        pkt_len   = '0;
        tready    = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_q.delete();
        obs_q.delete();
        len_q.delete();
        done_cnt  = 0;
        stab_viol = 0;
        stalled   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({tvalid, tlast, busy, pkt_done, din_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00001 (tvalid,tlast,busy,pkt_done,din_ready)",
                     {tvalid, tlast, busy, pkt_done, din_ready});
        end
        n_cmp++;
        if (tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 00", tdata); end
        n_cmp++;
        if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(b[i]);
        n_cmp++;
        if (fifo_count !== CW'(4)) begin n_err++; $display("FAIL basic_fill: got %0d want 4", fifo_count); end
        start = 1'b1; pkt_len = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({tvalid, tlast, tdata} !== {1'b1, (i == 3), b[i]}) begin
                n_err++;
                $display("FAIL basic_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                         i, tvalid, tlast, tdata, (i == 3), b[i]);
            end
            tick();
        end
        n_cmp++;
        if ({pkt_done, busy, fifo_count} !== {1'b1, 1'b0, CW'(0)}) begin
            n_err++;
            $display("FAIL basic_done: got done=%b busy=%b cnt=%0d want 1 0 0", pkt_done, busy, fifo_count);
        end
        tick();
        n_cmp++;
        if (pkt_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", pkt_done); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(b[i]);
        start = 1'b1; pkt_len = LEN_W'(4);
        tick();
        start = 1'b0;
        tick();
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 8'h22}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b l=%b d=%h want v=1 l=0 d=22", i, tvalid, tlast, tdata);
            end
            tick();
        end
        tready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL bp_end: busy got %b want 0", busy); end
        n_cmp++;
        if (obs_q.size() != total_beats()) begin
            n_err++; $display("FAIL bp_nbeats: got %0d want %0d", obs_q.size(), total_beats());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_beat(i)) begin
                n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_beat(i));
            end
        end
        n_cmp++;
        if (stab_viol != 0) begin n_err++; $display("FAIL bp_stable: got %0d violations want 0", stab_viol); end
    endtask

    task automatic test_underrun();
        do_reset();
        tready = 1'b1;
        push_byte(8'hA0);
        start = 1'b1; pkt_len = LEN_W'(3);
        tick();
        start = 1'b0;
        n_cmp++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 8'hA0}) begin
            n_err++; $display("FAIL ur_first: got v=%b l=%b d=%h want v=1 l=0 d=a0", tvalid, tlast, tdata);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (tvalid !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL ur_gap%0d: got tvalid=%b busy=%b want 0 1", i, tvalid, busy);
            end
            tick();
        end
        din = 8'hA1; din_valid = 1'b1;
        tick();
        din = 8'hA2;
        n_cmp++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 8'hA1}) begin
            n_err++; $display("FAIL ur_a1: got v=%b l=%b d=%h want v=1 l=0 d=a1", tvalid, tlast, tdata);
        end
        tick();
        din_valid = 1'b0;
        n_cmp++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b1, 8'hA2}) begin
            n_err++; $display("FAIL ur_a2: got v=%b l=%b d=%h want v=1 l=1 d=a2", tvalid, tlast, tdata);
        end
        tick();
        n_cmp++;
        if ({pkt_done, busy} !== 2'b10) begin
            n_err++; $display("FAIL ur_done: got done=%b busy=%b want 1 0", pkt_done, busy);
        end
    endtask

    task automatic test_full();
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(DATA_W'($urandom));
        n_cmp++;
        if ({din_ready, fifo_count} !== {1'b0, CW'(16)}) begin
            n_err++; $display("FAIL full_16: got ready=%b cnt=%0d want 0 16", din_ready, fifo_count);
        end
        push_byte(DATA_W'($urandom));
        n_cmp++;
        if (fifo_count !== CW'(16)) begin n_err++; $display("FAIL full_17th: got %0d want 16", fifo_count); end
        din = DATA_W'($urandom); din_valid = 1'b1;
        start = 1'b1; pkt_len = LEN_W'(40);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            din = DATA_W'($urandom);
            tick();
            n_cmp++;
            if (fifo_count !== CW'(15)) begin
                n_err++; $display("FAIL full_steady%0d: got %0d want 15", k, fifo_count);
            end
        end
        din_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL full_end: busy got %b want 0", busy); end
        n_cmp++;
        if (obs_q.size() != total_beats()) begin
            n_err++; $display("FAIL full_nbeats: got %0d want %0d", obs_q.size(), total_beats());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_beat(i)) begin
                n_err++; $display("FAIL full_beat%0d: got %h want %h", i, obs_q[i], exp_beat(i));
            end
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 2; i++) push_byte(DATA_W'($urandom));
        start = 1'b1; pkt_len = '0;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b1, push_q[0]}) begin
            n_err++; $display("FAIL len0_beat: got v=%b l=%b d=%h want v=1 l=1 d=%h", tvalid, tlast, tdata, push_q[0]);
        end
        tick();
        n_cmp++;
        if ({pkt_done, busy, fifo_count} !== {1'b1, 1'b0, CW'(1)}) begin
            n_err++; $display("FAIL len0_done: got done=%b busy=%b cnt=%0d want 1 0 1", pkt_done, busy, fifo_count);
        end
        for (int i = 0; i < 3; i++) push_byte(DATA_W'($urandom));
        tready = 1'b0;
        start = 1'b1; pkt_len = LEN_W'(3);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; pkt_len = LEN_W'(1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({busy, tlast} !== {1'b1, (i == 2)}) begin
                n_err++; $display("FAIL midstart_beat%0d: got busy=%b last=%b want 1 %b", i, busy, tlast, (i == 2));
            end
            tready = 1'b1;
            tick();
        end
        n_cmp++;
        if ({busy, pkt_done} !== 2'b01) begin
            n_err++; $display("FAIL midstart_end: got busy=%b done=%b want 0 1", busy, pkt_done);
        end
        n_cmp++;
        if (obs_q.size() != total_beats()) begin
            n_err++; $display("FAIL len0_nbeats: got %0d want %0d", obs_q.size(), total_beats());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_beat(i)) begin
                n_err++; $display("FAIL len0_stream%0d: got %h want %h", i, obs_q[i], exp_beat(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(DATA_W'($urandom));
        start = 1'b1; pkt_len = LEN_W'(3);
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tvalid, tlast, busy, pkt_done, din_ready} !== 5'b00001) begin
            n_err++; $display("FAIL rstmid_flags: got %b want 00001 (tvalid,tlast,busy,pkt_done,din_ready)",
                              {tvalid, tlast, busy, pkt_done, din_ready});
        end
        n_cmp++;
        if ({tdata, fifo_count} !== {DATA_W'(0), CW'(0)}) begin
            n_err++; $display("FAIL rstmid_data: got d=%h cnt=%0d want 00 0", tdata, fifo_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({tvalid, busy, fifo_count} !== {1'b0, 1'b0, CW'(0)}) begin
            n_err++; $display("FAIL rstmid_after: got v=%b busy=%b cnt=%0d want 0 0 0", tvalid, busy, fifo_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            din       = DATA_W'($urandom);
            din_valid = ($urandom_range(0, 2) != 0);
            tready    = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            pkt_len   = LEN_W'($urandom_range(0, 6));
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 500 && busy; i++) begin
            din       = DATA_W'($urandom);
            din_valid = $urandom_range(0, 1);
            tready    = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_end: busy got %b want 0", busy); end
        n_cmp++;
        if (obs_q.size() != total_beats()) begin
            n_err++; $display("FAIL rnd_nbeats: got %0d want %0d", obs_q.size(), total_beats());
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_beat(i)) begin
                n_err++; $display("FAIL rnd_beat%0d: got %h want %h", i, obs_q[i], exp_beat(i));
            end
        end
        n_cmp++;
        if (done_cnt != len_q.size()) begin
            n_err++; $display("FAIL rnd_done: got %0d pulses want %0d", done_cnt, len_q.size());
        end
        n_cmp++;
        if (int'(fifo_count) != push_q.size() - obs_q.size()) begin
            n_err++; $display("FAIL rnd_count: got %0d want %0d", fifo_count, push_q.size() - obs_q.size());
        end
        n_cmp++;
        if (stab_viol != 0) begin n_err++; $display("FAIL rnd_stable: got %0d violations want 0", stab_viol); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_full();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule : tb_axis_m_pkt_gen
